// File: rtl/sw_debounce_pkg.sv
// Shared constants for the switch debouncer: FSM encoding, glitch counter
// ceiling and a width helper used to validate the debounce counter size.
package sw_debounce_pkg;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SETTLE = 1'b1;

    localparam logic [7:0] GLITCH_CNT_MAX = 8'd255;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >>> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch bus between the raw pins, the debouncer and the counter stage.
// SW_DEBOUNCE_GLITCH_CNT_EN adds the o_glitch_cnt observation signal.
interface sw_debounce_if #(
    parameter int NB_SW = 3
);
    logic [NB_SW-1:0] i_sw_raw;
    logic [NB_SW-1:0] o_sw;
    logic             o_sw_changed;
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0]       o_glitch_cnt;

    modport master (output i_sw_raw, input o_sw, o_sw_changed, o_glitch_cnt);
    modport slave  (input i_sw_raw, output o_sw, o_sw_changed, o_glitch_cnt);
`else
    modport master (output i_sw_raw, input o_sw, o_sw_changed);
    modport slave  (input i_sw_raw, output o_sw, o_sw_changed);
`endif
endinterface

// File: rtl/sw_debounce_sync_2ff.sv
// Two-flop synchroniser for the raw switch vector; plain flop-to-flop path.
module sync_2ff #(
    parameter int NB_SW = 3
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic [NB_SW-1:0] i_d,
    output logic [NB_SW-1:0] o_q
);
    logic [NB_SW-1:0] s1;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            s1  <= '0;
            o_q <= '0;
        end else begin
            s1  <= i_d;
            o_q <= s1;
        end
    end
endmodule

// File: rtl/sw_debounce.sv
// Debounces the switch vector as one unit; o_sw only moves after DEBOUNCE_CYCLES
// stable samples. Define SW_DEBOUNCE_GLITCH_CNT_EN to count aborted candidates.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int NB_SW           = 3,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int NB_DBC          = 20
) (
    input  logic          clock,
    input  logic          i_reset,
    sw_debounce_if.slave  bus
);
    localparam logic [NB_DBC-1:0] CNT_LAST = NB_DBC'(DEBOUNCE_CYCLES - 1);

    if (NB_DBC < clog2(DEBOUNCE_CYCLES) || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("sw_debounce: NB_DBC too narrow for DEBOUNCE_CYCLES");
    end

    logic [NB_SW-1:0]  s2;
    logic [NB_SW-1:0]  cand;
    logic [NB_SW-1:0]  sw_q;
    logic [NB_DBC-1:0] cnt;
    logic [0:0]        state;
    logic              chg_q;

    sync_2ff #(.NB_SW(NB_SW)) u_sync (
        .clock   (clock),
        .i_reset (i_reset),
        .i_d     (bus.i_sw_raw),
        .o_q     (s2)
    );

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
            cand  <= '0;
            cnt   <= '0;
            sw_q  <= '0;
            chg_q <= 1'b0;
        end else begin
            chg_q <= 1'b0;
            if (state == ST_IDLE) begin
                if (s2 != sw_q) begin
                    state <= ST_SETTLE;
                    cand  <= s2;
                    cnt   <= '0;
                end
            end else if (s2 == cand) begin
                if (cnt == CNT_LAST) begin
                    sw_q  <= cand;
                    chg_q <= 1'b1;
                    cnt   <= '0;
                    state <= ST_IDLE;
                end else begin
                    cnt <= cnt + NB_DBC'(1);
                end
            end else if (s2 == sw_q) begin
                // bounced back to the accepted value: drop the candidate
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                cand <= s2;
                cnt  <= '0;
            end
        end
    end

    assign bus.o_sw         = sw_q;
    assign bus.o_sw_changed = chg_q;

`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_q;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            glitch_q <= '0;
        end else if (state == ST_SETTLE && s2 != cand && glitch_q != GLITCH_CNT_MAX) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign bus.o_glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Randomised + directed bench for sw_debounce; a run-length reference model feeds
// a scoreboard of expected o_sw_changed pulses, checked by an independent monitor.
module tb_sw_debounce;
    localparam int NB_SW = 3;
    localparam int DC    = 4;

    logic clock   = 1'b0;
    logic i_reset = 1'b0;

    sw_debounce_if #(.NB_SW(NB_SW)) bus ();

    sw_debounce #(.NB_SW(NB_SW), .DEBOUNCE_CYCLES(DC), .NB_DBC(20)) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #10 clock = ~clock;

    typedef struct {
        int               cyc;
        logic [NB_SW-1:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   n_pulse = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    endtask

    // Reference: the FSM sees the raw value from two edges back; a value different
    // from o_sw is accepted on the edge where it has been sampled DC+1 times in a row.
    logic [NB_SW-1:0] m_h1, m_h2, m_prev, m_sw;
    int               m_run;
    int               m_glitch;

    task automatic model_reset();
        m_h1 = '0; m_h2 = '0; m_prev = '0; m_sw = '0;
        m_run = 0; m_glitch = 0;
    endtask

    task automatic model_edge(input logic [NB_SW-1:0] raw);
        logic [NB_SW-1:0] sample;
        sample = m_h2;
        m_h2   = m_h1;
        m_h1   = raw;
        // a candidate was pending and the sample moved away from it
        if (m_prev != m_sw && sample != m_prev && m_glitch < 255) m_glitch = m_glitch + 1;
        m_run  = (sample == m_prev) ? m_run + 1 : 1;
        m_prev = sample;
        if (sample != m_sw && m_run == DC + 1) begin
            m_sw = sample;
            sb_q.push_back('{cyc + 1, sample});
        end
    endtask

    task automatic step(input logic [NB_SW-1:0] raw, input logic rst_n);
        @(negedge clock);
        bus.i_sw_raw = raw;
        i_reset      = rst_n;
        if (!rst_n) model_reset();
        else        model_edge(raw);
    endtask

    task automatic hold(input logic [NB_SW-1:0] raw, input int n);
        repeat (n) step(raw, 1'b1);
    endtask

    task automatic rst_step(input string name, input logic [NB_SW-1:0] raw);
        step(raw, 1'b0);
        #1;
        chk({name, "_sw"}, int'(bus.o_sw), 0);
        chk({name, "_chg"}, int'(bus.o_sw_changed), 0);
    endtask

    task automatic edge_chk(input string name, input logic [NB_SW-1:0] exp_sw, input logic exp_chg);
        @(posedge clock);
        #1;
        chk({name, "_sw"}, int'(bus.o_sw), int'(exp_sw));
        chk({name, "_chg"}, int'(bus.o_sw_changed), int'(exp_chg));
    endtask

    // Monitor: every pulse must match the scoreboard head; o_sw must never move silently.
    logic [NB_SW-1:0] last_sw = '0;
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (!i_reset) begin
            last_sw = bus.o_sw;
        end else begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                chk("pulse_missed_edge", cyc, sb_q[0].cyc);
                void'(sb_q.pop_front());
            end
            if (bus.o_sw_changed) begin
                n_pulse = n_pulse + 1;
                chk("pulse_expected", int'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("pulse_edge", cyc, e.cyc);
                    chk("pulse_value", int'(bus.o_sw), int'(e.val));
                end
            end else begin
                chk("sw_stable", int'(bus.o_sw), int'(last_sw));
            end
            last_sw = bus.o_sw;
        end
    end

    initial begin
        #5000000;
        $display("FAIL timeout: bench did not finish, edge %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        int n;
        logic [NB_SW-1:0] v;
        model_reset();
        bus.i_sw_raw = '0;

        // 1: reset holds outputs low, then 101 appears on edge 7 after release
        repeat (3) rst_step("reset_hold", 3'b101);
        hold(3'b101, 6);
        edge_chk("rel_e6", 3'b000, 1'b0);
        step(3'b101, 1'b1);
        edge_chk("rel_e7", 3'b101, 1'b1);

        // 2: clean step 000 -> 001
        hold(3'b000, 10);
        hold(3'b001, 6);
        edge_chk("step_e6", 3'b000, 1'b0);
        step(3'b001, 1'b1);
        edge_chk("step_e7", 3'b001, 1'b1);
        step(3'b001, 1'b1);
        edge_chk("step_e8", 3'b001, 1'b0);

        // 3: bounce 000 <-> 010 every 2 cycles, then settle on 010
        hold(3'b000, 10);
        repeat (2) begin
            hold(3'b010, 2);
            hold(3'b000, 2);
        end
        hold(3'b010, 6);
        edge_chk("bounce_e6", 3'b000, 1'b0);
        step(3'b010, 1'b1);
        edge_chk("bounce_e7", 3'b010, 1'b1);
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
        chk("glitch_seen", int'(bus.o_glitch_cnt != 8'd0), 1);
`endif

        // 4: third value restarts the candidate; 001 is never shown
        hold(3'b000, 10);
        hold(3'b001, 3);
        hold(3'b011, 6);
        edge_chk("third_e9", 3'b000, 1'b0);
        step(3'b011, 1'b1);
        edge_chk("third_e10", 3'b011, 1'b1);

        // 5: reset two edges into SETTLE discards the candidate
        hold(3'b110, 5);
        rst_step("mid_settle_rst", 3'b110);
        repeat (2) rst_step("mid_settle_hold", 3'b110);
        hold(3'b110, 6);
        edge_chk("mid_rel_e6", 3'b000, 1'b0);
        step(3'b110, 1'b1);
        edge_chk("mid_rel_e7", 3'b110, 1'b1);

        // 6: short bounces 000/001 then hold: downstream sees one transition
        hold(3'b000, 10);
        p0 = n_pulse;
        repeat (6) begin
            hold(3'b001, $urandom_range(1, 2));
            hold(3'b000, $urandom_range(1, 2));
        end
        hold(3'b001, 10);
        @(posedge clock);
        #2;
        chk("single_transition", n_pulse - p0, 1);
        chk("single_value", int'(bus.o_sw), 1);

        // random segments with occasional resets
        v = 3'b000;
        for (int seg = 0; seg < 80; seg++) begin
            if ($urandom_range(0, 19) == 0) begin
                n = $urandom_range(1, 3);
                repeat (n) step(v, 1'b0);
            end else begin
                v = NB_SW'($urandom_range(0, 7));
                n = $urandom_range(1, 9);
                hold(v, n);
            end
        end
        hold(v, 12);
        @(posedge clock);
        #2;
        chk("sb_drained", sb_q.size(), 0);
        chk("final_sw", int'(bus.o_sw), int'(m_sw));
`ifdef SW_DEBOUNCE_GLITCH_CNT_EN
        chk("glitch_cnt", int'(bus.o_glitch_cnt), m_glitch);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
